id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage: RV32IM decode, NREGS x XLEN register file, and a registered
//  ID/EX output slot with valid/ready handshake. Sits between the IF/ID and EX stages.
//  Provides write-first WB bypass, load-use hazard stall, flush, and held-operand refresh.
//  Decode now flags M-extension ops and illegal opcodes.
// PARAMETERS
//  XLEN   32  datapath width: reg values, imm, pc, wb_data
//  NREGS  32  architectural registers; power of 2, 2..32; AW = $clog2(NREGS)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      IF/ID holds a valid instruction
//  in_ready     out  1      stage accepts in_instr/in_pc this cycle
//  in_instr     in   32     instruction word
//  in_pc        in   XLEN   pc of in_instr
//  flush        in   1      kill the held and incoming instruction (branch/jump redirect)
//  ex_memread   in   1      the instruction in EX is a load
//  ex_rd        in   AW     destination register of the instruction in EX
//  wb_we        in   1      writeback enable
//  wb_rd        in   AW     writeback register
//  wb_data      in   XLEN   writeback data
//  out_valid    out  1      ID/EX slot valid
//  out_ready    in   1      EX consumes the slot this cycle
//  out_pc       out  XLEN   pc
//  out_rs1_val  out  XLEN   rs1 operand
//  out_rs2_val  out  XLEN   rs2 operand
//  out_imm      out  XLEN   sign-extended immediate (I/S/B/U/J)
//  out_rd, out_rs1, out_rs2  out  AW each  register indices; 0 when the format has no such field
//  out_funct3   out  3      funct3 (0 for U/J)
//  out_funct7   out  7      funct7 (R-type only, else 0)
//  out_ctrl     out  11     {RegWrite,ALUSrc,MemRead,MemWrite,Branch,Jump,Jump_r,memtoreg,ALUOp[1:0],is_muldiv}
//  out_illegal  out  1      opcode not in the RV32IM base set, or index >= NREGS
// BEHAVIOUR
//  Reset (one cycle): all regs and all out_* cleared to 0; in_ready=0 while rst=1.
//  Decode: combinational from in_instr. ALUOp: R=10, branch=01, AUIPC=11, else 00.
//   is_muldiv = opcode 0110011 && funct7 0000001. Illegal opcode -> ctrl all 0, out_illegal=1.
//  hazard = in_valid & ex_memread & ex_rd!=0 & (ex_rd==rs1 | ex_rd==rs2); rs1/rs2 counted only
//   when the format uses them.
//  slot_free = !out_valid | out_ready.
//  in_ready = slot_free & !hazard & !flush & !rst. An accept is in_valid & in_ready.
//  Accept: on the next edge the slot loads the decode results; out_valid=1. Latency is 1 cycle.
//  Hazard with slot_free: a bubble loads (out_valid=0). IF/ID must hold its instruction.
//   Re-evaluate every cycle.
//  slot_free, no accept, no hazard: out_valid <- 0.
//  Hold (out_valid & !out_ready): every out_* is stable, except the operand refresh below.
//  Operand read: x0 reads 0. Same-cycle write-first bypass:
//   wb_we & wb_rd==rs & rs!=0 -> wb_data.
//  Operand refresh during hold: wb_we & wb_rd!=0 & wb_rd==out_rs1 -> out_rs1_val <= wb_data.
//   Same rule for rs2.
//  Reg write: wb_we & wb_rd!=0 -> regs[wb_rd] <= wb_data. Writes to x0 are dropped.
//  flush: on the next edge out_valid <- 0 and nothing is accepted. flush beats hazard and hold.
//  rst beats flush. Asserting rst mid-operation drops the held slot and clears the regfile.
//  Simultaneous WB write and accept of the same register: the accepted operand is the new value.
// TESTING
//  1. ADDI x1,x0,5 accepted, out_ready=1 -> next cycle out_valid=1, imm=5, rd=1, ALUSrc=1, RegWrite=1.
//  2. wb_we x3=0xAA in the same cycle as accepting ADD x4,x3,x3 -> out_rs1_val = out_rs2_val = 0xAA.
//  3. ex_memread=1, ex_rd=2, in=ADD x5,x2,x1 -> in_ready=0 and a bubble for 1 cycle;
//     accepted the cycle after ex_memread drops.
//  4. out_ready=0 for 3 cycles holding rs1=6, WB x6=0x55 -> outputs stable,
//     out_rs1_val becomes 0x55 on the next cycle.
//  5. flush during hold plus in_valid -> next cycle out_valid=0 and no accept;
//     rst mid-stream -> x1..x31 read 0.
//  6. MUL x7,x1,x2 -> is_muldiv=1, ALUOp=10; opcode 0x7F -> out_illegal=1, ctrl=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32IM decode stage: instruction decode, NREGS x XLEN register file and a
// registered ID/EX slot with valid/ready handshake, load-use stall, flush and WB bypass.
module id_stage_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_memread,
  input  logic [AW-1:0]   ex_rd,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic [AW-1:0]   out_rs1,
  output logic [AW-1:0]   out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [10:0]     out_ctrl,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        use_rd, use_rs1, use_rs2, use_f3, use_f7, legal;
  logic        c_regwrite, c_alusrc, c_memread, c_memwrite;
  logic        c_branch, c_jump, c_jump_r, c_memtoreg, is_muldiv;
  logic [1:0]  aluop;

  logic [AW-1:0]   dec_rd, dec_rs1, dec_rs2;
  logic [2:0]      dec_f3;
  logic [6:0]      dec_f7;
  logic [10:0]     dec_ctrl;
  logic [XLEN-1:0] dec_imm, rs1_val, rs2_val;
  logic            dec_illegal, bad_idx;
  logic            hazard, slot_free, accept;

  function automatic logic idx_oob(input logic [4:0] idx);
    return 32'(idx) >= NREGS;
  endfunction

  assign opcode = in_instr[6:0];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_f3     = 1'b0;
    use_f7     = 1'b0;
    legal      = 1'b1;
    imm32      = '0;
    c_regwrite = 1'b0;
    c_alusrc   = 1'b0;
    c_memread  = 1'b0;
    c_memwrite = 1'b0;
    c_branch   = 1'b0;
    c_jump     = 1'b0;
    c_jump_r   = 1'b0;
    c_memtoreg = 1'b0;
    aluop      = 2'b00;
    case (opcode)
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
        c_regwrite = 1'b1;
        aluop      = 2'b10;
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        imm32      = imm_i;
        c_regwrite = 1'b1;
        c_alusrc   = 1'b1;
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        imm32      = imm_i;
        c_regwrite = 1'b1;
        c_alusrc   = 1'b1;
        c_memread  = 1'b1;
        c_memtoreg = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        imm32      = imm_s;
        c_alusrc   = 1'b1;
        c_memwrite = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        imm32    = imm_b;
        c_branch = 1'b1;
        aluop    = 2'b01;
      end
      OPC_JAL: begin
        use_rd     = 1'b1;
        imm32      = imm_j;
        c_regwrite = 1'b1;
        c_jump     = 1'b1;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        imm32      = imm_i;
        c_regwrite = 1'b1;
        c_alusrc   = 1'b1;
        c_jump_r   = 1'b1;
      end
      OPC_LUI: begin
        use_rd     = 1'b1;
        imm32      = imm_u;
        c_regwrite = 1'b1;
        c_alusrc   = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd     = 1'b1;
        imm32      = imm_u;
        c_regwrite = 1'b1;
        c_alusrc   = 1'b1;
        aluop      = 2'b11;
      end
      // Legal but inert in this pipeline: fields decoded, no control asserted.
      OPC_FENCE, OPC_SYSTEM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        imm32 = imm_i;
      end
      default: legal = 1'b0;
    endcase
  end

  assign is_muldiv   = (opcode == OPC_OP) && (in_instr[31:25] == 7'b0000001);
  assign dec_ctrl    = {c_regwrite, c_alusrc, c_memread, c_memwrite, c_branch,
                        c_jump, c_jump_r, c_memtoreg, aluop, is_muldiv};
  assign dec_imm     = XLEN'(signed'(imm32));
  assign dec_rd      = use_rd  ? in_instr[7 +: AW]  : '0;
  assign dec_rs1     = use_rs1 ? in_instr[15 +: AW] : '0;
  assign dec_rs2     = use_rs2 ? in_instr[20 +: AW] : '0;
  assign dec_f3      = use_f3  ? in_instr[14:12]    : '0;
  assign dec_f7      = use_f7  ? in_instr[31:25]    : '0;
  assign bad_idx     = (use_rd  && idx_oob(in_instr[11:7]))  ||
                       (use_rs1 && idx_oob(in_instr[19:15])) ||
                       (use_rs2 && idx_oob(in_instr[24:20]));
  assign dec_illegal = !legal || bad_idx;

  // Write-first: a same-cycle writeback wins over the stored value.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (dec_rs1 != '0)
      rs1_val = (wb_we && wb_rd == dec_rs1) ? wb_data : regs[dec_rs1];
    if (dec_rs2 != '0)
      rs2_val = (wb_we && wb_rd == dec_rs2) ? wb_data : regs[dec_rs2];
  end

  // Unused source fields decode to 0, and ex_rd==0 never stalls.
  assign hazard    = in_valid && ex_memread && (ex_rd != '0) &&
                     ((ex_rd == dec_rs1) || (ex_rd == dec_rs2));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush && !rst;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[AW'(i)] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_rs1_val <= rs1_val;
        out_rs2_val <= rs2_val;
        out_imm     <= dec_imm;
        out_rd      <= dec_rd;
        out_rs1     <= dec_rs1;
        out_rs2     <= dec_rs2;
        out_funct3  <= dec_f3;
        out_funct7  <= dec_f7;
        out_ctrl    <= dec_ctrl;
        out_illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      // Held slot: track writebacks so EX never sees a stale operand.
      if (wb_we && wb_rd != '0 && wb_rd == out_rs1)
        out_rs1_val <= wb_data;
      if (wb_we && wb_rd != '0 && wb_rd == out_rs2)
        out_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against a
// transaction-level model of the decode stage.
module tb_id_stage_pipe;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, ex_memread, wb_we;
  logic            out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, wb_data, out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [AW-1:0]   ex_rd, wb_rd, out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [10:0]     out_ctrl;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mregs [32];

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [10:0] ctrl;
    logic        ill;
  } exp_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // Expected decode, table-driven by instruction format.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [31:0] ii, is_, ib, iu, ij;
    ii  = {{20{ins[31]}}, ins[31:20]};
    is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = {ins[31:12], 12'h000};
    ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '0;
    case (ins[6:0])
      7'h33: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
                   e.f7 = ins[31:25]; e.ctrl = (ins[31:25] == 7'h01) ? 11'h405 : 11'h404; end
      7'h13: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.f3 = ins[14:12]; e.imm = ii; e.ctrl = 11'h600; end
      7'h03: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.f3 = ins[14:12]; e.imm = ii; e.ctrl = 11'h708; end
      7'h23: begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12]; e.imm = is_; e.ctrl = 11'h280; end
      7'h63: begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12]; e.imm = ib; e.ctrl = 11'h042; end
      7'h6F: begin e.rd = ins[11:7]; e.imm = ij; e.ctrl = 11'h420; end
      7'h67: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.f3 = ins[14:12]; e.imm = ii; e.ctrl = 11'h610; end
      7'h37: begin e.rd = ins[11:7]; e.imm = iu; e.ctrl = 11'h600; end
      7'h17: begin e.rd = ins[11:7]; e.imm = iu; e.ctrl = 11'h606; end
      7'h0F, 7'h73: begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.f3 = ins[14:12]; e.imm = ii; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else if (wb_we && wb_rd != 0) begin
      mregs[wb_rd] = wb_data;
    end
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; ex_memread = 0; ex_rd = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0; out_ready = 1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    step();
    tests++;
    if ({out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rs1, out_rs2,
         out_funct3, out_funct7, out_ctrl, out_illegal} !== '0) begin
      fails++; $display("FAIL reset_outputs: got valid=%b ctrl=%h imm=%h want all 0", out_valid, out_ctrl, out_imm);
    end
    rst = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    do_reset();
    in_valid = 1; in_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13); in_pc = 32'h100;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL addi_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    tests++; if (out_imm !== 32'd5) begin fails++; $display("FAIL addi_imm: got %h want 5", out_imm); end
    tests++; if (out_rd !== 5'd1) begin fails++; $display("FAIL addi_rd: got %0d want 1", out_rd); end
    tests++; if (out_ctrl !== 11'h600) begin fails++; $display("FAIL addi_ctrl: got %h want 600", out_ctrl); end
    tests++; if (out_pc !== 32'h100) begin fails++; $display("FAIL addi_pc: got %h want 100", out_pc); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'hAA;
    in_valid = 1; in_instr = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33);
    step();
    wb_we = 0;
    in_instr = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd5, 7'h33);
    tests++; if (out_rs1_val !== 32'hAA) begin fails++; $display("FAIL bypass_rs1: got %h want aa", out_rs1_val); end
    tests++; if (out_rs2_val !== 32'hAA) begin fails++; $display("FAIL bypass_rs2: got %h want aa", out_rs2_val); end
    tests++; if (out_ctrl !== 11'h404) begin fails++; $display("FAIL add_ctrl: got %h want 404", out_ctrl); end
    step();
    in_valid = 0;
    tests++; if (out_rs1_val !== 32'hAA) begin fails++; $display("FAIL regfile_x3: got %h want aa", out_rs1_val); end
    tests++; if (out_rs2_val !== 32'h0) begin fails++; $display("FAIL x0_read: got %h want 0", out_rs2_val); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1; ex_rd = 5'd2;
    in_valid = 1; in_instr = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd5, 7'h33);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hazard_ready: got %b want 0", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hazard_bubble: got %b want 0", out_valid); end
    ex_memread = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hazard_release: got %b want 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin
      fails++; $display("FAIL hazard_accept: got valid=%b rd=%0d want valid=1 rd=5", out_valid, out_rd); end
    ex_memread = 1; ex_rd = 5'd2;
    in_instr = enc_i(12'd2, 5'd1, 3'd0, 5'd5, 7'h13);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL itype_no_rs2_hazard: got %b want 1", in_ready); end
    ex_rd = 5'd1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL itype_rs1_hazard: got %b want 0", in_ready); end
    ex_rd = 5'd0;
    in_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5, 7'h33);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_no_hazard: got %b want 1", in_ready); end
    step();
    ex_memread = 0; in_valid = 0;
  endtask

  task automatic test_hold_refresh();
    do_reset();
    in_valid = 1; in_instr = enc_r(7'h00, 5'd7, 5'd6, 3'd0, 5'd8, 7'h33); in_pc = 32'h200;
    step();
    out_ready = 0;
    in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13); in_pc = 32'h204;
    wb_we = 1; wb_rd = 5'd6; wb_data = 32'h55;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_ready: got %b want 0", in_ready); end
    step();
    tests++; if (out_rs1_val !== 32'h55) begin fails++; $display("FAIL refresh_rs1: got %h want 55", out_rs1_val); end
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_pc !== 32'h200) begin
      fails++; $display("FAIL hold_stable1: got valid=%b rd=%0d pc=%h want 1 8 200", out_valid, out_rd, out_pc); end
    wb_rd = 5'd7; wb_data = 32'h77;
    step();
    tests++; if (out_rs2_val !== 32'h77 || out_rs1_val !== 32'h55) begin
      fails++; $display("FAIL refresh_rs2: got %h %h want 55 77", out_rs1_val, out_rs2_val); end
    wb_rd = 5'd0; wb_data = 32'h99;
    step();
    tests++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || out_rs1_val !== 32'h55 || out_rs2_val !== 32'h77) begin
      fails++; $display("FAIL hold_stable3: got valid=%b rd=%0d v1=%h v2=%h", out_valid, out_rd, out_rs1_val, out_rs2_val); end
    wb_we = 0; out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hold_release: got %b want 1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (out_rd !== 5'd9 || out_imm !== 32'd1 || out_pc !== 32'h204) begin
      fails++; $display("FAIL after_hold: got rd=%0d imm=%h pc=%h want 9 1 204", out_rd, out_imm, out_pc); end
    step();
  endtask

  task automatic test_flush_reset();
    do_reset();
    in_valid = 1; in_instr = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33);
    step();
    out_ready = 0; flush = 1;
    in_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd4, 7'h13);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_kill: got %b want 0", out_valid); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_accept: got %b want 0", out_valid); end
    for (int k = 1; k < 32; k++) begin
      wb_we = 1; wb_rd = 5'(k); wb_data = 32'h1000 + 32'(k);
      step();
    end
    wb_we = 0;
    in_valid = 1; in_instr = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd1, 7'h33);
    step();
    tests++; if (out_rs1_val !== 32'h1005) begin fails++; $display("FAIL fill_x5: got %h want 1005", out_rs1_val); end
    out_ready = 0; rst = 1;
    step();
    rst = 0; in_valid = 0; out_ready = 1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_drop: got %b want 0", out_valid); end
    for (int k = 1; k < 32; k++) begin
      in_valid = 1; in_instr = enc_r(7'h00, 5'(k), 5'(k), 3'd0, 5'd1, 7'h33);
      step();
      tests++; if ({out_rs1_val, out_rs2_val} !== 64'h0) begin
        fails++; $display("FAIL rst_clear_x%0d: got %h %h want 0", k, out_rs1_val, out_rs2_val); end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_muldiv_illegal();
    do_reset();
    in_valid = 1; in_instr = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33);
    step();
    tests++; if (out_ctrl !== 11'h405 || out_funct7 !== 7'h01 || out_illegal !== 1'b0) begin
      fails++; $display("FAIL mul_decode: got ctrl=%h f7=%h ill=%b want 405 01 0", out_ctrl, out_funct7, out_illegal); end
    in_instr = 32'h0000007F;
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ctrl !== 11'h000) begin
      fails++; $display("FAIL illegal_decode: got valid=%b ill=%b ctrl=%h want 1 1 000", out_valid, out_illegal, out_ctrl); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs [12];
    logic [31:0] ins, v1, v2, m_pc, m_v1, m_v2;
    logic        m_valid, hz, free, rdy;
    exp_t        d, m_d;
    int          sel;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F};
    do_reset();
    m_valid = 0; m_pc = '0; m_v1 = '0; m_v2 = '0; m_d = '0;
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0]   = opcs[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      if (ins[6:0] == 7'h33) begin
        sel = $urandom_range(0, 2);
        ins[31:25] = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h01 : 7'h20;
      end
      in_instr   = ins;
      in_pc      = $urandom;
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      ex_memread = ($urandom_range(0, 9) < 3);
      ex_rd      = 5'($urandom_range(0, 7));
      wb_we      = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      #1;
      d    = ref_decode(ins);
      hz   = in_valid && ex_memread && ex_rd != 0 && (ex_rd == d.rs1 || ex_rd == d.rs2);
      free = !m_valid || out_ready;
      rdy  = free && !hz && !flush;
      tests++; if (in_ready !== rdy) begin fails++; $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, rdy); end
      v1 = (d.rs1 == 0) ? 32'h0 : (wb_we && wb_rd == d.rs1) ? wb_data : mregs[d.rs1];
      v2 = (d.rs2 == 0) ? 32'h0 : (wb_we && wb_rd == d.rs2) ? wb_data : mregs[d.rs2];
      if (flush) m_valid = 0;
      else if (free) begin
        if (in_valid && rdy) begin
          m_valid = 1; m_pc = in_pc; m_v1 = v1; m_v2 = v2; m_d = d;
        end else m_valid = 0;
      end else begin
        if (wb_we && wb_rd != 0 && wb_rd == m_d.rs1) m_v1 = wb_data;
        if (wb_we && wb_rd != 0 && wb_rd == m_d.rs2) m_v2 = wb_data;
      end
      step();
      tests++; if (out_valid !== m_valid) begin fails++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, m_valid); end
      if (m_valid) begin
        tests++;
        if ({out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_ctrl, out_illegal}
            !== {m_pc, m_v1, m_v2, m_d.imm, m_d.rd, m_d.rs1, m_d.rs2, m_d.f3, m_d.f7, m_d.ctrl, m_d.ill}) begin
          fails++;
          $display("FAIL rand_slot[%0d]: got pc=%h v1=%h v2=%h imm=%h rd=%0d ctrl=%h ill=%b want pc=%h v1=%h v2=%h imm=%h rd=%0d ctrl=%h ill=%b",
                   n, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_ctrl, out_illegal,
                   m_pc, m_v1, m_v2, m_d.imm, m_d.rd, m_d.ctrl, m_d.ill);
        end
      end
    end
    drive_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wb_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush_reset();
    test_muldiv_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
